// File: rtl/fft_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg
// Shared definitions for the FFT bin packer: default sample width and frame
// length, and the packer state encoding.
// -----------------------------------------------------------------------------
package fft_pkg;

  // Default component width (two's complement) and bins per frame.
  localparam int FFT_DW_DEF   = 12;
  localparam int FFT_NFFT_DEF = 256;

  // IDLE : outside a frame, waiting for a bin carrying s_sop
  // EVEN : inside a frame, awaiting bin 2k
  // ODD  : inside a frame, holding bin 2k, awaiting bin 2k+1
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVEN = 2'd1,
    ODD  = 2'd2
  } pack_state_e;

endpackage

// File: rtl/fft_pair_reg.sv
// -----------------------------------------------------------------------------
// fft_pair_reg
// Single-entry holding register with valid/ready on both sides. The payload
// and valid flag are registered; in_ready is high whenever the register is
// empty or is being drained in the same cycle, so the producer sees a fully
// registered output stage with no bubble on continuous flow.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   load request from the producer / space available
//   in_data  [W-1:0]      payload to load
//   out_valid / out_ready held payload valid / consumer accepts
//   out_data [W-1:0]      held payload (stable while out_valid & !out_ready)
// -----------------------------------------------------------------------------
module fft_pair_reg
  import fft_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid_r;
  logic [W-1:0] data_r;

  assign in_ready  = !valid_r | out_ready;
  assign out_valid = valid_r;
  assign out_data  = data_r;

  // Holding register: only updates when empty or being handed off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
      data_r  <= {W{1'b0}};
    end else if (in_ready) begin
      valid_r <= in_valid;
      if (in_valid) begin
        data_r <= in_data;
      end
    end
  end

endmodule

// File: rtl/fft_bin_pack.sv
// -----------------------------------------------------------------------------
// fft_bin_pack
// Packs a stream of complex FFT bins (one bin per transfer) into pairs of
// bins (2k, 2k+1) for the downstream magnitude stage. Frames are delimited by
// s_sop/s_eop; an odd-length frame ends with a zero-padded pair. Framing
// faults (s_sop inside a frame, or a frame running to bin NFFT-1 without
// s_eop) raise a one-cycle err pulse and are recovered automatically.
//
// Build option
//   FFT_PACK_POS_BINS_EN  when defined, bins with index >= NFFT/2 are accepted
//                         and discarded; pair NFFT/4-1 carries m_eop and
//                         s_eop (or bin NFFT-1) still closes the frame.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   s_valid, s_ready           input bin handshake
//   s_re, s_im  [DW-1:0]       bin real / imaginary part
//   s_sop, s_eop               first / last bin of a frame
//   m_valid, m_ready           output pair handshake
//   Y0, Y1      [DW-1:0]       re / im of bin 2k
//   Y2, Y3      [DW-1:0]       re / im of bin 2k+1 (zero on a padded pair)
//   m_idx [log2(NFFT)-2:0]     pair index k
//   m_sop, m_eop               first / last pair of a frame
//   err                        one-cycle framing error pulse
// -----------------------------------------------------------------------------
module fft_bin_pack
  import fft_pkg::*;
#(
  parameter int DW   = FFT_DW_DEF,
  parameter int NFFT = FFT_NFFT_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [DW-1:0]              s_re,
  input  logic [DW-1:0]              s_im,
  input  logic                       s_sop,
  input  logic                       s_eop,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [DW-1:0]              Y0,
  output logic [DW-1:0]              Y1,
  output logic [DW-1:0]              Y2,
  output logic [DW-1:0]              Y3,
  output logic [$clog2(NFFT)-2:0]    m_idx,
  output logic                       m_sop,
  output logic                       m_eop,
  output logic                       err
);

  localparam int CW = $clog2(NFFT);     // bin index width
  localparam int IW = CW - 1;           // pair index width
  localparam int PW = 4 * DW + IW + 2;  // packed pair payload width

  pack_state_e       state_r;
  logic [CW-1:0]     bin_cnt_r;   // index of the next bin expected in the frame
  logic [DW-1:0]     half_re_r;   // held even bin
  logic [DW-1:0]     half_im_r;
  logic              err_r;

  logic              s_ready_s;
  logic              xfer_s;
  logic              start_s;     // transfer opening a new frame
  logic              active_s;    // in-frame transfer without s_sop
  logic [CW-1:0]     bin_idx_s;   // index of the bin being transferred
  logic              last_bin_s;
  logic              eop_eff_s;   // frame ends with this bin
  logic              packed_s;    // bin falls in the packed range
  logic              pack_end_s;  // bin closes the packed range early
  logic              emit_s;
  logic              err_s;
  logic [DW-1:0]     y0_s, y1_s, y2_s, y3_s;
  logic [IW-1:0]     idx_s;
  logic              psop_s;
  logic              peop_s;
  logic [PW-1:0]     pair_s;
  logic [PW-1:0]     pair_q_s;

  // Transfer decode and pair formation for the current input bin.
  always_comb begin
    xfer_s     = s_valid & s_ready_s;
    start_s    = xfer_s & s_sop;
    active_s   = xfer_s & !s_sop & (state_r != IDLE);
    // An s_sop always restarts the frame at bin 0, whatever the counter says.
    bin_idx_s  = s_sop ? {CW{1'b0}} : bin_cnt_r;
    last_bin_s = (bin_idx_s == CW'(NFFT - 1));
    eop_eff_s  = s_eop | last_bin_s;
`ifdef FFT_PACK_POS_BINS_EN
    packed_s   = (bin_idx_s < CW'(NFFT / 2));
    pack_end_s = (bin_idx_s == CW'(NFFT / 2 - 1));
`else
    packed_s   = 1'b1;
    pack_end_s = 1'b0;
`endif

    y0_s   = s_re;
    y1_s   = s_im;
    y2_s   = {DW{1'b0}};
    y3_s   = {DW{1'b0}};
    idx_s  = bin_idx_s[CW-1:1];
    psop_s = (idx_s == {IW{1'b0}});
    peop_s = 1'b1;

    if (start_s) begin
      // Single-bin frame: the opening bin is also the last one.
      emit_s = s_eop;
    end else if (active_s && (state_r == ODD)) begin
      emit_s = 1'b1;
      y0_s   = half_re_r;
      y1_s   = half_im_r;
      y2_s   = s_re;
      y3_s   = s_im;
      peop_s = eop_eff_s | pack_end_s;
    end else if (active_s && (state_r == EVEN)) begin
      // Odd-length frame: pad the final even bin with a zero partner.
      emit_s = packed_s & eop_eff_s;
    end else begin
      emit_s = 1'b0;
    end

    err_s  = (start_s & (state_r != IDLE)) | (active_s & last_bin_s & !s_eop);
    pair_s = {y0_s, y1_s, y2_s, y3_s, idx_s, psop_s, peop_s};
  end

  // Framing FSM: tracks frame position, holds the even bin, registers err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      bin_cnt_r <= {CW{1'b0}};
      half_re_r <= {DW{1'b0}};
      half_im_r <= {DW{1'b0}};
      err_r     <= 1'b0;
    end else begin
      err_r <= err_s;
      if (start_s) begin
        half_re_r <= s_re;
        half_im_r <= s_im;
        if (s_eop) begin
          state_r   <= IDLE;
          bin_cnt_r <= {CW{1'b0}};
        end else begin
          state_r   <= ODD;
          bin_cnt_r <= CW'(1);
        end
      end else if (active_s) begin
        case (state_r)
          ODD: begin
            if (eop_eff_s) begin
              state_r   <= IDLE;
              bin_cnt_r <= {CW{1'b0}};
            end else begin
              state_r   <= EVEN;
              bin_cnt_r <= bin_cnt_r + CW'(1);
            end
          end
          EVEN: begin
            if (eop_eff_s) begin
              state_r   <= IDLE;
              bin_cnt_r <= {CW{1'b0}};
            end else begin
              // Outside the packed range bins are counted but not held.
              if (packed_s) begin
                half_re_r <= s_re;
                half_im_r <= s_im;
                state_r   <= ODD;
              end
              bin_cnt_r <= bin_cnt_r + CW'(1);
            end
          end
          default: begin
            state_r   <= IDLE;
            bin_cnt_r <= {CW{1'b0}};
          end
        endcase
      end
    end
  end

  fft_pair_reg #(
    .W (PW)
  ) u_pair_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (emit_s),
    .in_ready  (s_ready_s),
    .in_data   (pair_s),
    .out_valid (m_valid),
    .out_ready (m_ready),
    .out_data  (pair_q_s)
  );

  assign s_ready = s_ready_s;
  assign err     = err_r;
  assign {Y0, Y1, Y2, Y3, m_idx, m_sop, m_eop} = pair_q_s;

endmodule

// File: tb/tb_fft_bin_pack.sv
module tb_fft_bin_pack;

  localparam int DW   = 12;
  localparam int NFFT = 8;
  localparam int IW   = $clog2(NFFT) - 1;
`ifdef FFT_PACK_POS_BINS_EN
  localparam int PACK = NFFT / 2;
`else
  localparam int PACK = NFFT;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_re = '0;
  logic [DW-1:0] s_im = '0;
  logic          s_sop = 1'b0;
  logic          s_eop = 1'b0;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [DW-1:0] Y0, Y1, Y2, Y3;
  logic [IW-1:0] m_idx;
  logic          m_sop, m_eop, err;

  fft_bin_pack #(.DW(DW), .NFFT(NFFT)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_re(s_re), .s_im(s_im),
    .s_sop(s_sop), .s_eop(s_eop),
    .m_valid(m_valid), .m_ready(m_ready),
    .Y0(Y0), .Y1(Y1), .Y2(Y2), .Y3(Y3),
    .m_idx(m_idx), .m_sop(m_sop), .m_eop(m_eop), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] y0, y1, y2, y3;
    logic [IW-1:0] idx;
    logic          sop;
    logic          eop;
  } pair_t;

  pair_t exp_q[$];
  pair_t obs_q[$];
  int    checks = 0;
  int    failures = 0;
  int    err_seen = 0;
  int    exp_err = 0;
  int    stall_left = 0;
  bit    rnd_ready = 1'b0;

  // reference model state: frame membership, bins seen so far, held even bin
  bit            in_frame = 1'b0;
  int            nbin = 0;
  logic [DW-1:0] held_re, held_im;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic pair_t mk(input logic [DW-1:0] a, b, c, d, input int k, input bit sp, input bit ep);
    pair_t p;
    p.y0 = a; p.y1 = b; p.y2 = c; p.y3 = d;
    p.idx = IW'(k); p.sop = sp; p.eop = ep;
    return p;
  endfunction

  // Frame-level rules: pairs are (bin 2k, bin 2k+1) of the current frame.
  task automatic model_accept(input logic [DW-1:0] re, im, input logic sop, eop);
    int  i;
    bit  last;
    if (sop) begin
      if (in_frame) exp_err++;
      in_frame = 1'b1;
      nbin = 0;
    end
    if (in_frame) begin
      i = nbin;
      last = eop || (i == NFFT - 1);
      if (i == NFFT - 1 && !eop) exp_err++;
      if (i < PACK) begin
        if (i % 2 == 0) begin
          held_re = re; held_im = im;
          if (last) exp_q.push_back(mk(re, im, '0, '0, i / 2, i == 0, 1'b1));
        end else begin
          exp_q.push_back(mk(held_re, held_im, re, im, i / 2, (i / 2) == 0, last || (i == PACK - 1)));
        end
      end
      nbin++;
      if (last) in_frame = 1'b0;
    end
  endtask

  task automatic send_bin(input logic [DW-1:0] re, im, input logic sop, eop);
    int guard = 0;
    @(negedge clk);
    s_valid = 1'b1; s_re = re; s_im = im; s_sop = sop; s_eop = eop;
    #1;
    while (!s_ready && guard < 200) begin
      @(negedge clk); #1; guard++;
    end
    chk("send_accept", 64'(s_ready), 64'd1);
    if (s_ready) model_accept(re, im, sop, eop);
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    s_valid = 1'b0; s_sop = 1'b0; s_eop = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    int g = 0;
    idle(1);
    while ((exp_q.size() != 0 || m_valid) && g < 200) begin
      @(negedge clk); g++;
    end
    repeat (3) @(negedge clk);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    chk("err_count", 64'(err_seen), 64'(exp_err));
  endtask

  task automatic chk_reset_outputs();
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_y", 64'({Y0, Y1, Y2, Y3}), 64'd0);
    chk("rst_idx_sop_eop", 64'({m_idx, m_sop, m_eop}), 64'd0);
  endtask

  // Output side: drives m_ready, scores handoffs, checks hold stability.
  initial begin : mon
    pair_t cur, held_p, e;
    bit    prev_hold = 1'b0;
    forever begin
      @(negedge clk);
      if (stall_left > 0) begin
        m_ready = 1'b0;
        stall_left--;
      end else if (rnd_ready) begin
        m_ready = 1'($urandom_range(0, 1));
      end else begin
        m_ready = 1'b1;
      end
      #1;
      cur = {Y0, Y1, Y2, Y3, m_idx, m_sop, m_eop};
      if (!rst_n) begin
        prev_hold = 1'b0;
      end else begin
        if (err === 1'b1) err_seen++;
        if (prev_hold) begin
          chk("hold_valid", 64'(m_valid), 64'd1);
          chk("hold_data", 64'(cur), 64'(held_p));
        end
        if (m_valid && !m_ready) begin
          chk("stall_s_ready", 64'(s_ready), 64'd0);
          held_p = cur;
          prev_hold = 1'b1;
        end else begin
          prev_hold = 1'b0;
        end
        if (m_valid && m_ready) begin
          chk("pair_expected", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("pair", 64'(cur), 64'(e));
            obs_q.push_back(cur);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int eb;
    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk_reset_outputs();
    chk("rst_s_ready", 64'(s_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // full frame, re = n, im = -n, always ready
    obs_q.delete();
    for (int n = 0; n < NFFT; n++) send_bin(DW'(n), DW'(-n), n == 0, n == NFFT - 1);
    drain();
`ifndef FFT_PACK_POS_BINS_EN
    chk("f8_pairs", 64'(obs_q.size()), 64'd4);
    if (obs_q.size() >= 4) begin
      chk("f8_p1_y0", 64'(obs_q[1].y0), 64'd2);
      chk("f8_p1_y1", 64'(obs_q[1].y1), 64'hFFE);
      chk("f8_p1_y2", 64'(obs_q[1].y2), 64'd3);
      chk("f8_p1_y3", 64'(obs_q[1].y3), 64'hFFD);
      chk("f8_sop", 64'({obs_q[0].sop, obs_q[1].sop, obs_q[3].sop}), 64'b100);
      chk("f8_eop", 64'({obs_q[2].eop, obs_q[3].eop}), 64'b01);
      chk("f8_idx3", 64'(obs_q[3].idx), 64'd3);
    end
`endif

    // 5-cycle back-pressure mid-frame
    obs_q.delete();
    for (int n = 0; n < NFFT; n++) begin
      if (n == 4) stall_left = 5;
      send_bin(DW'($urandom), DW'($urandom), n == 0, n == NFFT - 1);
    end
    drain();
    chk("stall_pairs", 64'(obs_q.size()), 64'(PACK / 2));

    // 5-bin frame: final pair zero-padded
    obs_q.delete();
    for (int n = 0; n < 5; n++) send_bin(DW'(n), DW'(-n), n == 0, n == 4);
    drain();
`ifndef FFT_PACK_POS_BINS_EN
    chk("f5_pairs", 64'(obs_q.size()), 64'd3);
    if (obs_q.size() >= 3) begin
      chk("f5_p2", 64'({obs_q[2].y0, obs_q[2].y1, obs_q[2].y2, obs_q[2].y3}),
          64'({12'd4, 12'hFFC, 12'd0, 12'd0}));
      chk("f5_p2_eop", 64'({obs_q[2].idx, obs_q[2].eop}), 64'({2'd2, 1'b1}));
    end
`endif

    // s_sop at bin 3 restarts the frame
    obs_q.delete();
    eb = err_seen;
    for (int n = 0; n < 7; n++) send_bin(DW'(n), DW'(-n), n == 0 || n == 3, n == 6);
    drain();
    chk("resop_err_pulses", 64'(err_seen - eb), 64'd1);
    chk("resop_pairs", 64'(obs_q.size()), 64'd3);
    if (obs_q.size() >= 3) begin
      chk("resop_new_p0", 64'({obs_q[1].y0, obs_q[1].y2, obs_q[1].idx, obs_q[1].sop}),
          64'({12'd3, 12'd4, 2'd0, 1'b1}));
    end

    // runaway frame: no s_eop, bins past NFFT-1 are discarded
    obs_q.delete();
    eb = err_seen;
    for (int n = 0; n < NFFT + 2; n++) send_bin(DW'(n + 100), DW'(n), n == 0, 1'b0);
    drain();
    chk("ovf_err_pulses", 64'(err_seen - eb), 64'd1);
    chk("ovf_pairs", 64'(obs_q.size()), 64'(PACK / 2));

    // randomized frames with random back-pressure and stray markers
    rnd_ready = 1'b1;
    for (int f = 0; f < 30; f++) begin
      int len = $urandom_range(1, 10);
      int pre = $urandom_range(0, 2);
      for (int g = 0; g < pre; g++)
        send_bin(DW'($urandom), DW'($urandom), 1'b0, 1'($urandom_range(0, 1)));
      for (int b = 0; b < len; b++)
        send_bin(DW'($urandom), DW'($urandom), (b == 0) || ($urandom_range(0, 11) == 0), b == len - 1);
      if ($urandom_range(0, 3) == 0) idle(2);
    end
    drain();
    rnd_ready = 1'b0;

    // reset with a pair pending, then reset while holding bin 0
    send_bin(DW'(7), DW'(8), 1'b1, 1'b0);
    stall_left = 8;
    send_bin(DW'(9), DW'(10), 1'b0, 1'b0);
    #3 rst_n = 1'b0;
    #1 chk_reset_outputs();
    exp_q.delete(); in_frame = 1'b0; stall_left = 0;
    @(negedge clk);
    s_valid = 1'b0;
    rst_n = 1'b1;
    idle(1);
    send_bin(DW'(11), DW'(12), 1'b1, 1'b0);
    #3 rst_n = 1'b0;
    #1 chk("rst_odd_m_valid", 64'(m_valid), 64'd0);
    exp_q.delete(); in_frame = 1'b0;
    @(negedge clk);
    s_valid = 1'b0;
    rst_n = 1'b1;
    obs_q.delete();
    eb = err_seen;
    for (int n = 1; n < 4; n++) send_bin(DW'(n), DW'(n), 1'b0, n == 3);
    drain();
    chk("post_rst_no_pairs", 64'(obs_q.size()), 64'd0);
    chk("post_rst_no_err", 64'(err_seen - eb), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fft_bin_pack.md
FFT_BIN_PACK -- requirements
Module: fft_bin_pack

Interface
REQ-001 SHALL have parameter DW, default 12, meaning sample width of each real/imag component, two's complement.
REQ-002 SHALL have parameter NFFT, default 256, meaning bins per frame (power of two, >= 8).
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst_n, input, 1, meaning reset, asynchronous and active-low.
REQ-005 SHALL have ports s_valid (in, 1), s_ready (out, 1), s_re (in, DW), s_im (in, DW), s_sop (in, 1), s_eop (in, 1), meaning the FFT bin stream, one bin per transfer.
REQ-006 SHALL have ports m_valid (out, 1), m_ready (in, 1), Y0, Y1, Y2, Y3 (out, DW each), meaning the packed bin pair for the magnitude stage: Y0/Y1 = re/im of bin 2k, Y2/Y3 = re/im of bin 2k+1.
REQ-007 SHALL have ports m_idx (out, log2(NFFT)-1), m_sop (out, 1), m_eop (out, 1), meaning pair index k and frame markers.
REQ-008 SHALL have port err (out, 1), meaning a one-cycle framing-error pulse.

Function
REQ-009 A transfer SHALL occur on s_valid & s_ready; output handoff SHALL occur on m_valid & m_ready.
REQ-010 s_ready SHALL equal !m_valid | m_ready; no combinational path from s_valid to s_ready.
REQ-011 FSM states SHALL be IDLE, EVEN (awaiting bin 2k), and ODD (holding bin 2k).
REQ-012 IDLE: transfers without s_sop SHALL be accepted and discarded; a transfer with s_sop SHALL load the half-register, clear the bin counter, and go to ODD.
REQ-013 ODD: the next transfer SHALL load Y0..Y3, m_idx = k, and set m_valid on the following edge (latency 1 cycle from second-bin acceptance), then go to EVEN, or to IDLE if s_eop.
REQ-014 EVEN: a transfer SHALL load the half-register and go to ODD; if it carries s_eop, a pair SHALL be emitted with Y2 = Y3 = 0 and m_eop = 1, then go to IDLE.
REQ-015 m_sop SHALL be 1 only on pair 0; m_eop SHALL be 1 only on the frame's last pair.
REQ-016 m_valid and Y0..Y3, m_idx, m_sop and m_eop SHALL be held stable while m_valid & !m_ready.
REQ-017 An s_sop in EVEN or ODD SHALL pulse err, drop any held half-bin, and start a new frame with that bin.
REQ-018 A transfer at bin NFFT-1 without s_eop SHALL be treated as s_eop and SHALL pulse err.
REQ-019 An s_eop with s_sop in IDLE (single-bin frame) SHALL emit one pair with Y2 = Y3 = 0 and m_sop = m_eop = 1.

Reset
REQ-020 While rst_n = 0: state = IDLE, m_valid = 0, err = 0, Y0..Y3 = 0, m_idx = 0, m_sop = m_eop = 0, bin counter = 0.
REQ-021 Reset mid-frame SHALL discard any partial pair with no err pulse; the first bin accepted after release SHALL require s_sop.

Configuration
REQ-022 Macro FFT_PACK_POS_BINS_EN: when defined, bins with index >= NFFT/2 SHALL be accepted and discarded, m_eop SHALL mark pair NFFT/4-1, and s_eop SHALL still end the frame.
REQ-023 When FFT_PACK_POS_BINS_EN is undefined, all bins SHALL be packed.

Structure
REQ-024 The state enum and the default DW/NFFT constants SHALL live in the shared package fft_pkg.
REQ-025 The output register slice SHALL be the sub-module fft_pair_reg, a holding register with valid/ready.

Verification
REQ-026 Frame of NFFT = 8 bins, re = n, im = -n, m_ready = 1 -> 4 pairs; pair 1 has Y0 = 2, Y1 = -2, Y2 = 3, Y3 = -3; m_sop on pair 0, m_eop on pair 3.
REQ-027 m_ready held 0 for 5 cycles mid-frame -> s_ready = 0, outputs stable, no bin lost.
REQ-028 5-bin frame -> pair 2 has Y0 = 4, Y1 = -4, Y2 = Y3 = 0 and m_eop = 1.
REQ-029 s_sop at bin 3 -> err pulses for one cycle, new pair 0 built from that bin.
REQ-030 rst_n low while state = ODD -> m_valid = 0 immediately; bins without s_sop are ignored afterwards.
REQ-031 With FFT_PACK_POS_BINS_EN and NFFT = 16 -> exactly 4 pairs, m_eop on m_idx = 3.
